// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR sequencer.
//   - fir_state_e : tap-sequencing FSM states
//   - NTAPS_DEF   : default number of taps
//   - DW_DEF      : default sample / coefficient / output width
//   - COEF_RESET  : value every coefficient takes on reset
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int NTAPS_DEF  = 3;
    localparam int DW_DEF     = 8;
    localparam int COEF_RESET = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fir_state_e;

endpackage : fir_pkg

// File: rtl/fir_mac_step.sv
// -----------------------------------------------------------------------------
// fir_mac_step
// One combinational multiply-accumulate step: o_acc = i_acc + low_DW(i_coef * i_sample).
// This is the only multiplier and adder of the FIR sequencer; every tap is
// pushed through it in turn. All arithmetic wraps modulo 2^DW.
// Ports:
//   i_acc    in  DW  running accumulator
//   i_coef   in  DW  coefficient b[k]
//   i_sample in  DW  delay-line sample x[k]
//   o_acc    out DW  updated accumulator
// -----------------------------------------------------------------------------
module fir_mac_step
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_acc,
    input  logic [DW-1:0] i_coef,
    input  logic [DW-1:0] i_sample,
    output logic [DW-1:0] o_acc
);

    // The DW-wide evaluation context keeps only the low DW bits of the product,
    // which is exactly the truncation the filter arithmetic calls for.
    logic [DW-1:0] w_prod;

    assign w_prod = i_coef * i_sample;
    assign o_acc  = i_acc + w_prod;

endmodule : fir_mac_step

// File: rtl/fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl
// Time-multiplexed NTAPS-tap FIR: one output per accepted input sample, computed
// one tap per cycle through a single shared multiply-accumulate step.
// Owns the sample delay line, the coefficient register file and the FSM.
// Ports:
//   clk       in  1   clock, rising edge
//   rst_n     in  1   synchronous reset, active-high (1 = reset)
//   in_valid  in  1   input sample valid
//   in_ready  out 1   block can accept a sample (IDLE only)
//   in_data   in  DW  input sample x[n], unsigned
//   out_valid out 1   output sample valid
//   out_ready in  1   downstream accepts output
//   out_data  out DW  y[n], unsigned, wraps modulo 2^DW
//   cfg_we    in  1   coefficient write strobe
//   cfg_addr  in  AW  coefficient index k
//   cfg_data  in  DW  coefficient value b[k]
//   cfg_err   out 1   one-cycle pulse: a cfg write was dropped
//   busy      out 1   high in RUN or DONE
// -----------------------------------------------------------------------------
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_err,
    output logic          busy
);

    localparam logic [AW-1:0] K_LAST  = AW'(NTAPS - 1);
    localparam logic [31:0]   NTAPS_U = 32'(NTAPS);

    // ---------------------------------------------------------------- state
    fir_state_e    r_state;
    fir_state_e    w_state_nxt;

    logic [DW-1:0] r_x    [NTAPS];
    logic [DW-1:0] r_coef [NTAPS];
    logic [DW-1:0] r_acc;
    logic [AW-1:0] r_k;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_cfg_err;

    // ---------------------------------------------------------------- controls
    logic          w_shift;      // accept sample: shift delay line, clear acc
    logic          w_step;       // one MAC step this cycle
    logic          w_out_load;   // last tap: latch result
    logic          w_out_clr;    // result consumed downstream
    logic          w_addr_ok;
    logic          w_cfg_ok;
    logic [DW-1:0] w_coef_sel;
    logic [DW-1:0] w_x_sel;
    logic [DW-1:0] w_mac;

    assign w_addr_ok  = (32'(cfg_addr) < NTAPS_U);
    assign w_cfg_ok   = (r_state == ST_IDLE) && w_addr_ok;
    assign w_coef_sel = r_coef[r_k];
    assign w_x_sel    = r_x[r_k];

    fir_mac_step #(
        .DW (DW)
    ) u_mac (
        .i_acc    (r_acc),
        .i_coef   (w_coef_sel),
        .i_sample (w_x_sel),
        .o_acc    (w_mac)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_step      = 1'b0;
        w_out_load  = 1'b0;
        w_out_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_k == K_LAST) begin
                    w_out_load  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                // Returning to IDLE takes this edge, so no sample is taken
                // in the cycle out_valid drops.
                if (out_ready) begin
                    w_out_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Delay line: newest sample enters at x[0] on each accepted input
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= {DW{1'b0}};
            end
        end else if (w_shift) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
                r_x[i] <= r_x[i-1];
            end
            r_x[0] <= in_data;
        end
    end

    // Coefficient register file, writable only from IDLE with an in-range address
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= DW'(COEF_RESET);
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_coef[cfg_addr] <= cfg_data;
        end
    end

    // Dropped-write flag, high for the cycle after the rejected strobe
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    // Accumulator and tap index
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_acc <= {DW{1'b0}};
            r_k   <= {AW{1'b0}};
        end else if (w_shift) begin
            r_acc <= {DW{1'b0}};
            r_k   <= {AW{1'b0}};
        end else if (w_step) begin
            r_acc <= w_mac;
            // Park the index at 0 after the last tap so it never leaves the array.
            r_k   <= (r_k == K_LAST) ? {AW{1'b0}} : (r_k + AW'(1));
        end
    end

    // Output register: result captured on the last tap, held through DONE
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_out_data  <= {DW{1'b0}};
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            r_out_data  <= w_mac;
            r_out_valid <= 1'b1;
        end else if (w_out_clr) begin
            r_out_valid <= 1'b0;
        end
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_err   = r_cfg_err;
    assign busy      = r_busy;

endmodule : fir_seq_ctrl

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Time-multiplexed FIR sequencer that computes one NTAPS-tap FIR output per accepted input sample using a single shared multiply-accumulate step.
- Owns the sample delay line, the coefficient register file and the tap-sequencing FSM.
- Valid/ready handshakes on input and output streams; cfg write port loads coefficients.
- Replaces the fully parallel per-tap multiplier/adder FIR where area matters more than throughput.

Parameters:
NTAPS, 3, number of taps (>=2)
DW, 8, sample, coefficient and output width
AW, $clog2(NTAPS), tap index / cfg address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1)
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DW  input sample x[n], unsigned
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  DW  y[n], unsigned
cfg_we  in  1  coefficient write strobe
cfg_addr  in  AW  coefficient index k
cfg_data  in  DW  coefficient value b[k]
cfg_err  out  1  one-cycle pulse: cfg write dropped
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=1 at an edge): state=IDLE; delay line x[0..NTAPS-1]=0; all b[k]=1; acc=0; out_data=0; out_valid=0; cfg_err=0; in_ready=1 from the next cycle. Reset overrides every other event, including mid-RUN/DONE; the in-flight result is discarded.
- y[n] = sum over k of b[k]*x[n-k]; x[0] is the newest sample.
- Arithmetic: each product is the low DW bits of b[k]*x[k]; the accumulator is DW bits and wraps modulo 2^DW. No saturation.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, shift the delay line (x[k]<=x[k-1], x[0]<=in_data), acc<=0, k<=0, go to RUN.
  - RUN: in_ready=0. One tap per cycle: acc<=acc+b[k]*x[k], k<=k+1. After the k=NTAPS-1 step, latch out_data<=final sum, out_valid<=1, go to DONE.
  - DONE: out_valid=1; out_data held stable. On out_ready, out_valid<=0 and go to IDLE.
- Latency:
  - Input handshake at edge T gives out_valid=1 visible after edge T+NTAPS, i.e. NTAPS+1 cycles.
  - Throughput: one sample per NTAPS+2 cycles with out_ready held high.
  - No input is accepted in the cycle out_valid drops.
- Backpressure: out_ready low holds DONE indefinitely; out_data unchanged; in_ready=0.
- Config writes:
  - cfg_we in IDLE writes b[cfg_addr]<=cfg_data at that edge.
  - cfg_we in RUN/DONE is dropped, cfg_err=1 for exactly the next cycle, coefficients unchanged.
  - cfg_addr>=NTAPS is dropped with cfg_err.
  - cfg_we and an input handshake at the same IDLE edge: the write lands first in effect, and the new coefficient is used for this sample.
- busy = (state != IDLE).

Decomposition:
- Shared package fir_pkg:
  - state enum {IDLE, RUN, DONE}
  - DW/NTAPS defaults
  - COEF_RESET = 1
- One sub-module fir_mac_step: combinational acc_out = acc_in + low-DW(b*x). It holds the only multiplier and adder in the block.

Test Plan:
- Default coefficients (all 1), NTAPS=3, out_ready=1, inputs 5,7,9 -> outputs 5,12,21; each out_valid appears 4 cycles after its input handshake.
- Write b=2,3,4 in IDLE, then impulse 1,0,0 -> outputs 2,3,4; cfg_err stays 0.
- b all 1, inputs 200,200,200 -> outputs 200,144,88 (modulo-256 wrap).
- out_ready held low 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0 throughout; the next input is accepted only after out_ready is asserted and IDLE is re-entered.
- cfg_we (addr 0, data 9) during RUN -> cfg_err pulses for 1 cycle; the subsequent impulse still yields the previous b[0]. A write to addr 3 in IDLE also gives cfg_err.
- Assert rst_n for 1 cycle mid-RUN -> out_valid=0, out_data=0, b reverts to 1, delay line cleared; next input 4 -> output 4.
